// File: rtl/smt_pkg.sv
// Types and constants shared by the SMT front-end blocks (fetch PC generator, arbiter).
package smt_pkg;

    typedef logic tid_t;

    localparam int NUM_THREADS = 2;

    // Width of a counter that must hold every value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/smt_fetch_thread_ctx.sv
// One thread's fetch context: fetch PC, outstanding-request credits and stale-response discard count.
module smt_fetch_thread_ctx
    import smt_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int FETCH_BYTES = 16,
    parameter int MAX_OUT = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            load,
    input  logic            resp,
    output logic            can_req,
    output logic [XLEN-1:0] aligned_pc,
    output logic            keep
);

    localparam int CW = cnt_width(MAX_OUT);
    localparam logic [XLEN-1:0] BLK_MASK = XLEN'(FETCH_BYTES - 1);
    localparam logic [XLEN-1:0] BLK_STEP = XLEN'(FETCH_BYTES);
    localparam logic [CW-1:0]   MAX_CNT  = CW'(MAX_OUT);

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   out_cnt;
    logic [CW-1:0]   out_cnt_next;
    logic [CW-1:0]   disc_cnt;

    assign aligned_pc = pc & ~BLK_MASK;
    assign can_req    = enable && !stall && !redirect && (out_cnt < MAX_CNT);
    assign keep       = (disc_cnt == '0);

    always_comb begin
        out_cnt_next = out_cnt;
        if (load && !resp) begin
            out_cnt_next = out_cnt + CW'(1);
        end else if (resp && !load) begin
            out_cnt_next = out_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            out_cnt  <= '0;
            disc_cnt <= '0;
        end else begin
            out_cnt <= out_cnt_next;
            // A redirect marks everything still in flight as stale, after this cycle's response.
            if (redirect) begin
                pc       <= redirect_pc;
                disc_cnt <= out_cnt_next;
            end else begin
                if (load) begin
                    pc <= aligned_pc + BLK_STEP;
                end
                if (resp && !keep) begin
                    disc_cnt <= disc_cnt - CW'(1);
                end
            end
        end
    end

    a_resp_underflow: assert property (@(posedge clk) disable iff (rst) resp |-> (out_cnt != '0));

endmodule

// File: rtl/smt_fetch_pc_gen.sv
// Two-thread fetch PC generator: per-thread request lines to the arbiter, a single-entry
// I-cache request register loaded on grant, and keep/discard classification of responses.
module smt_fetch_pc_gen
    import smt_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int FETCH_BYTES = 16,
    parameter int MAX_OUT = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      t_enable,
    input  logic [1:0]      t_stall,
    input  logic [1:0]      redirect_valid,
    input  logic [XLEN-1:0] t0_redirect_pc,
    input  logic [XLEN-1:0] t1_redirect_pc,
    output logic            t0_req,
    output logic            t1_req,
    input  logic            grant_t0,
    input  logic            grant_t1,
    output logic            icache_req_valid,
    input  logic            icache_req_ready,
    output logic [XLEN-1:0] icache_req_pc,
    output logic            icache_req_tid,
    input  logic            icache_resp_valid,
    input  logic            icache_resp_tid,
    output logic            resp_keep
);

    logic                   slot_free;
    logic [NUM_THREADS-1:0] can_req;
    logic [NUM_THREADS-1:0] load;
    logic [NUM_THREADS-1:0] resp;
    logic [NUM_THREADS-1:0] keep;
    logic [XLEN-1:0]        redir_pc   [NUM_THREADS];
    logic [XLEN-1:0]        aligned_pc [NUM_THREADS];

    // Ready feeds straight into the request lines so back-to-back issue sustains one per cycle.
    assign slot_free = !icache_req_valid || icache_req_ready;
    assign t0_req    = !rst && can_req[0] && slot_free;
    assign t1_req    = !rst && can_req[1] && slot_free;
    assign load      = {grant_t1 && t1_req, grant_t0 && t0_req};

    assign resp[0]   = icache_resp_valid && (icache_resp_tid == tid_t'(0));
    assign resp[1]   = icache_resp_valid && (icache_resp_tid == tid_t'(1));
    assign resp_keep = !rst && icache_resp_valid && keep[icache_resp_tid];

    assign redir_pc[0] = t0_redirect_pc;
    assign redir_pc[1] = t1_redirect_pc;

    for (genvar i = 0; i < NUM_THREADS; i++) begin : g_ctx
        smt_fetch_thread_ctx #(
            .XLEN        (XLEN),
            .FETCH_BYTES (FETCH_BYTES),
            .MAX_OUT     (MAX_OUT),
            .RESET_PC    (RESET_PC)
        ) u_ctx (
            .clk         (clk),
            .rst         (rst),
            .enable      (t_enable[i]),
            .stall       (t_stall[i]),
            .redirect    (redirect_valid[i]),
            .redirect_pc (redir_pc[i]),
            .load        (load[i]),
            .resp        (resp[i]),
            .can_req     (can_req[i]),
            .aligned_pc  (aligned_pc[i]),
            .keep        (keep[i])
        );
    end

    // A held request is never retracted; it only leaves on ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            icache_req_valid <= 1'b0;
            icache_req_pc    <= '0;
            icache_req_tid   <= 1'b0;
        end else if (|load) begin
            icache_req_valid <= 1'b1;
            icache_req_pc    <= load[1] ? aligned_pc[1] : aligned_pc[0];
            icache_req_tid   <= load[1];
        end else begin
            icache_req_valid <= icache_req_valid && !icache_req_ready;
        end
    end

endmodule

// File: tb/tb_smt_fetch_pc_gen.sv
// Bench for smt_fetch_pc_gen: table vectors, directed corner sequences and random traffic
// checked against an epoch-tagged in-flight model.
module tb_smt_fetch_pc_gen;

    localparam int XLEN = 64;
    localparam int FB = 16;
    localparam int MAX_OUT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      t_enable, t_stall, redirect_valid;
    logic [XLEN-1:0] t0_redirect_pc, t1_redirect_pc;
    logic            t0_req, t1_req, grant_t0, grant_t1;
    logic            icache_req_valid, icache_req_ready;
    logic [XLEN-1:0] icache_req_pc;
    logic            icache_req_tid;
    logic            icache_resp_valid, icache_resp_tid, resp_keep;

    smt_fetch_pc_gen #(.XLEN(XLEN), .FETCH_BYTES(FB), .MAX_OUT(MAX_OUT), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst), .t_enable(t_enable), .t_stall(t_stall),
        .redirect_valid(redirect_valid), .t0_redirect_pc(t0_redirect_pc),
        .t1_redirect_pc(t1_redirect_pc), .t0_req(t0_req), .t1_req(t1_req),
        .grant_t0(grant_t0), .grant_t1(grant_t1), .icache_req_valid(icache_req_valid),
        .icache_req_ready(icache_req_ready), .icache_req_pc(icache_req_pc),
        .icache_req_tid(icache_req_tid), .icache_resp_valid(icache_resp_valid),
        .icache_resp_tid(icache_resp_tid), .resp_keep(resp_keep)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: each granted request carries the thread's epoch at grant time;
    // a redirect bumps the epoch, so a response is kept iff its epoch is still current.
    logic [63:0] m_pc [2];
    int          m_epoch [2];
    int          q_out [2][$];
    logic        m_rv;
    logic [63:0] m_rpc;
    logic        m_rtid;
    int          m_last;
    typedef struct { int tid; int cyc; } acc_t;
    acc_t        acc_q [$];
    int          cyc = 0;

    logic        d_rst;
    logic [1:0]  d_en, d_stall, d_redir;
    logic [63:0] d_rpc0, d_rpc1;
    logic        d_ready;
    int          d_gmode, d_rmode, d_rtid, d_lat, d_req_lit, d_keep_lit;

    typedef struct {
        logic [1:0] en;
        logic [1:0] stall;
        logic [1:0] redir;
        logic       ready;
        logic [1:0] exp_req;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = '0;
            m_epoch[i] = 0;
            q_out[i].delete();
        end
        m_rv = 1'b0;
        m_rpc = '0;
        m_rtid = 1'b0;
        m_last = 1;
        acc_q.delete();
    endtask

    task automatic defaults();
        d_rst = 1'b0; d_en = 2'b00; d_stall = 2'b00; d_redir = 2'b00;
        d_rpc0 = '0; d_rpc1 = '0; d_ready = 1'b1;
        d_gmode = 1; d_rmode = 0; d_rtid = 0; d_lat = 2;
        d_req_lit = -1; d_keep_lit = -1;
    endtask

    // One clock: check registered outputs, drive inputs, check combinational outputs,
    // act as arbiter, then advance the model across the edge. Entered and left at negedge.
    task automatic cycle();
        logic [1:0] er;
        logic       slot, ek, rv_resp;
        int         gsel, rtid, idx;
        chk("req_valid", 64'(icache_req_valid), 64'(m_rv));
        chk("req_pc", icache_req_pc, m_rpc);
        chk("req_tid", 64'(icache_req_tid), 64'(m_rtid));

        rv_resp = 1'b0; rtid = 0; idx = -1;
        if (d_rst) begin
            rv_resp = (d_rmode != 0);
            rtid = d_rtid;
        end else if (d_rmode == 1) begin
            for (int k = 0; k < acc_q.size(); k++)
                if (idx < 0 && acc_q[k].tid == d_rtid) idx = k;
            if (idx >= 0) begin
                rv_resp = 1'b1;
                rtid = d_rtid;
            end else begin
                n_vec++; n_bad++;
                $display("FAIL resp_avail: no accepted request on thread %0d to answer", d_rtid);
            end
        end else if (d_rmode == 2 && acc_q.size() > 0 && cyc >= acc_q[0].cyc + d_lat) begin
            rv_resp = 1'b1;
            rtid = acc_q[0].tid;
            idx = 0;
        end

        rst = d_rst;
        t_enable = d_en;
        t_stall = d_stall;
        redirect_valid = d_redir;
        t0_redirect_pc = d_rpc0;
        t1_redirect_pc = d_rpc1;
        icache_req_ready = d_ready;
        icache_resp_valid = rv_resp;
        icache_resp_tid = rtid[0];
        grant_t0 = 1'b0;
        grant_t1 = 1'b0;
        #1;

        slot = !m_rv || d_ready;
        for (int i = 0; i < 2; i++)
            er[i] = !d_rst && d_en[i] && !d_stall[i] && !d_redir[i] &&
                    (q_out[i].size() < MAX_OUT) && slot;
        chk("t0_req", 64'(t0_req), 64'(er[0]));
        chk("t1_req", 64'(t1_req), 64'(er[1]));
        if (d_req_lit >= 0) chk("req_lines", 64'({t1_req, t0_req}), 64'(d_req_lit));
        ek = 1'b0;
        if (rv_resp && !d_rst) ek = (q_out[rtid][0] == m_epoch[rtid]);
        if (rv_resp) chk("resp_keep", 64'(resp_keep), 64'(ek));
        if (d_keep_lit >= 0) chk("resp_keep_exp", 64'(resp_keep), 64'(d_keep_lit));

        gsel = -1;
        if (er == 2'b11) begin
            case (d_gmode)
                1: gsel = 0;
                2: gsel = 1;
                3: gsel = int'($urandom_range(0, 1));
                4: gsel = (m_last == 1) ? 0 : 1;
                default: gsel = -1;
            endcase
        end else if (d_gmode != 0 && er[0]) begin
            gsel = 0;
        end else if (d_gmode != 0 && er[1]) begin
            gsel = 1;
        end
        grant_t0 = (gsel == 0);
        grant_t1 = (gsel == 1);

        @(posedge clk);
        if (d_rst) begin
            model_reset();
        end else begin
            if (rv_resp) begin
                void'(q_out[rtid].pop_front());
                acc_q.delete(idx);
            end
            if (m_rv && d_ready) acc_q.push_back('{int'(m_rtid), cyc});
            for (int i = 0; i < 2; i++) begin
                if (d_redir[i]) begin
                    m_epoch[i]++;
                    m_pc[i] = (i == 0) ? d_rpc0 : d_rpc1;
                end
            end
            if (gsel >= 0) begin
                q_out[gsel].push_back(m_epoch[gsel]);
                m_rpc = m_pc[gsel] & ~(64'(FB) - 64'd1);
                m_pc[gsel] = m_rpc + 64'(FB);
                m_rv = 1'b1;
                m_rtid = gsel[0];
                m_last = gsel;
            end else begin
                m_rv = m_rv && !d_ready;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        defaults();
        d_rst = 1'b1;
        d_req_lit = 0;
        cycle();
        defaults();
    endtask

    task automatic drain();
        int budget = 0;
        d_en = 2'b00; d_redir = 2'b00; d_ready = 1'b1; d_gmode = 0;
        d_rmode = 2; d_lat = 0; d_req_lit = -1; d_keep_lit = -1;
        while ((q_out[0].size() + q_out[1].size()) != 0 && budget < 40) begin
            cycle();
            budget++;
        end
        n_vec++;
        if (budget >= 40) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d/%0d still outstanding after %0d cycles",
                     q_out[0].size(), q_out[1].size(), budget);
        end
        defaults();
    endtask

    initial begin
        vecs[0]  = '{2'b11, 2'b00, 2'b00, 1'b1, 2'b11};
        vecs[1]  = '{2'b11, 2'b00, 2'b00, 1'b0, 2'b11};
        vecs[2]  = '{2'b01, 2'b00, 2'b00, 1'b1, 2'b01};
        vecs[3]  = '{2'b10, 2'b00, 2'b00, 1'b1, 2'b10};
        vecs[4]  = '{2'b11, 2'b01, 2'b00, 1'b1, 2'b10};
        vecs[5]  = '{2'b11, 2'b10, 2'b00, 1'b0, 2'b01};
        vecs[6]  = '{2'b11, 2'b00, 2'b01, 1'b1, 2'b10};
        vecs[7]  = '{2'b11, 2'b00, 2'b10, 1'b0, 2'b01};
        vecs[8]  = '{2'b00, 2'b00, 2'b00, 1'b1, 2'b00};
        vecs[9]  = '{2'b11, 2'b11, 2'b00, 1'b1, 2'b00};
        vecs[10] = '{2'b11, 2'b00, 2'b11, 1'b1, 2'b00};
        vecs[11] = '{2'b01, 2'b10, 2'b10, 1'b1, 2'b01};

        rst = 1'b1; t_enable = '0; t_stall = '0; redirect_valid = '0;
        t0_redirect_pc = '0; t1_redirect_pc = '0; grant_t0 = 1'b0; grant_t1 = 1'b0;
        icache_req_ready = 1'b1; icache_resp_valid = 1'b0; icache_resp_tid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        defaults();

        // Request-line truth table from an idle, empty state (no grants given).
        d_gmode = 0;
        foreach (vecs[v]) begin
            d_en = vecs[v].en; d_stall = vecs[v].stall; d_redir = vecs[v].redir;
            d_ready = vecs[v].ready; d_req_lit = int'(vecs[v].exp_req);
            cycle();
        end

        // Single thread: 0x0, 0x10, credit stall at two, resume at 0x20 after one response.
        do_reset();
        chk("rst_valid", 64'(icache_req_valid), 64'd0);
        chk("rst_pc", icache_req_pc, 64'd0);
        chk("rst_tid", 64'(icache_req_tid), 64'd0);
        d_en = 2'b01;
        cycle(); chk("seq1_pc0", icache_req_pc, 64'h0);
        cycle(); chk("seq1_pc1", icache_req_pc, 64'h10);
        cycle(); chk("seq1_credit_stall", 64'(t0_req), 64'd0);
        d_rmode = 1; d_rtid = 0;
        cycle();
        d_rmode = 0;
        cycle(); chk("seq1_pc2", icache_req_pc, 64'h20);
        drain();

        // Both threads, round-robin grants, responses two cycles after acceptance.
        do_reset();
        d_en = 2'b11; d_gmode = 4; d_rmode = 2; d_lat = 2;
        cycle(); chk("seq2_tid0", 64'(icache_req_tid), 64'd0);
        cycle(); chk("seq2_tid1", 64'(icache_req_tid), 64'd1);
        cycle(); chk("seq2_tid2", 64'(icache_req_tid), 64'd0);
        chk("seq2_t0_pc", icache_req_pc, 64'h10);
        cycle(); chk("seq2_tid3", 64'(icache_req_tid), 64'd1);
        chk("seq2_t1_pc", icache_req_pc, 64'h10);
        repeat (8) cycle();
        drain();

        // T1 request held under ready low for five cycles.
        do_reset();
        d_en = 2'b10;
        cycle();
        d_en = 2'b11; d_ready = 1'b0; d_req_lit = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("seq3_hold_pc", icache_req_pc, 64'h0);
            chk("seq3_hold_tid", 64'(icache_req_tid), 64'd1);
        end
        d_en = 2'b00; d_ready = 1'b1; d_req_lit = -1; d_gmode = 0;
        cycle(); chk("seq3_accepted", 64'(icache_req_valid), 64'd0);
        drain();

        // Redirect with two outstanding: two drops, then 0x1230 is kept.
        do_reset();
        d_en = 2'b01;
        cycle(); cycle();
        d_en = 2'b00; d_redir = 2'b01; d_rpc0 = 64'h1234;
        cycle();
        d_redir = 2'b00; d_rmode = 1; d_rtid = 0; d_keep_lit = 0;
        cycle(); cycle();
        d_rmode = 0; d_keep_lit = -1; d_en = 2'b01;
        cycle(); chk("seq4_new_pc", icache_req_pc, 64'h1230);
        d_en = 2'b00;
        cycle();
        d_rmode = 1; d_keep_lit = 1;
        cycle();
        drain();

        // Redirect coinciding with a response: that one is kept, exactly one more dropped.
        do_reset();
        d_en = 2'b01;
        cycle(); cycle();
        d_en = 2'b00; d_rmode = 1; d_rtid = 0; d_redir = 2'b01; d_rpc0 = 64'h500; d_keep_lit = 1;
        cycle();
        d_redir = 2'b00; d_keep_lit = 0;
        cycle();
        d_rmode = 0; d_keep_lit = -1; d_en = 2'b01;
        cycle(); chk("seq5_new_pc", icache_req_pc, 64'h500);
        d_en = 2'b00;
        cycle();
        d_rmode = 1; d_keep_lit = 1;
        cycle();
        drain();

        // PC wrap at the top of the address space.
        do_reset();
        d_redir = 2'b01; d_rpc0 = 64'hFFFF_FFFF_FFFF_FFF8;
        cycle();
        d_redir = 2'b00; d_en = 2'b01;
        cycle(); chk("seq6_top_pc", icache_req_pc, 64'hFFFF_FFFF_FFFF_FFF0);
        cycle(); chk("seq6_wrap_pc", icache_req_pc, 64'h0);
        drain();

        // Reset in the middle of traffic.
        d_en = 2'b11; d_gmode = 3; d_rmode = 2; d_lat = 1;
        repeat (6) cycle();
        d_rst = 1'b1; d_rmode = 1; d_rtid = 1; d_req_lit = 0; d_keep_lit = 0;
        cycle();
        chk("seq7_valid", 64'(icache_req_valid), 64'd0);
        chk("seq7_pc", icache_req_pc, 64'd0);
        chk("seq7_tid", 64'(icache_req_tid), 64'd0);
        defaults();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            d_rst   = ($urandom_range(0, 499) == 0);
            d_en    = {($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0)};
            d_stall = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            d_redir = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
            d_rpc0  = {32'($urandom), 32'($urandom)};
            d_rpc1  = {32'($urandom), 32'($urandom)};
            d_ready = ($urandom_range(0, 3) != 0);
            d_gmode = 3;
            d_rmode = d_rst ? 0 : 2;
            d_lat   = int'($urandom_range(0, 3));
            cycle();
        end
        defaults();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
